// File: rtl/x7seg_pkg.sv
// rtl/x7seg_pkg.sv - shared types and constants for the seven-segment display arbiter
//
// Purpose: digit width, blank code, default digit-buffer type and arbiter state
//          encoding shared by x7seg_prio_arb and x7seg_disp_arb.
// Ports:   none (package).
package x7seg_pkg;

  localparam int          DIGIT_W    = 4;
  localparam logic [3:0]  BLANK_CODE = 4'hF;
  localparam int          PKG_DIGITS = 8;

  typedef logic [PKG_DIGITS-1:0][DIGIT_W-1:0] digit_buf_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/x7seg_prio_arb.sv
// rtl/x7seg_prio_arb.sv - combinational fixed-priority one-hot picker
//
// Purpose: grants the lowest-index request that is also enabled by the mask.
// Ports:
//   req_i   [N]   request vector
//   mask_i  [N]   enable mask; only masked-in requests may win
//   gnt_o   [N]   one-hot grant (all zero when nothing eligible)
//   idx_o   [IW]  binary index of the granted request (0 when none)
module x7seg_prio_arb #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0] elig;
  logic         found;

  assign elig = req_i & mask_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (elig[i] && !found) begin
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/x7seg_disp_arb.sv
// rtl/x7seg_disp_arb.sv - display-ownership arbiter and digit buffer for the 7-seg scan driver
//
// Purpose: grants the shared 8-digit display to one producer at a time with a
//          minimum hold window, latching the granted frame into a register.
// Macro:   X7SEG_PREEMPT_EN - when defined, higher-priority requesters may take
//          the display during another owner's hold window.
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   req_valid  [NUM_REQ]            frame pending per requester
//   req_data   [NUM_REQ*DIGITS*4]   flattened frames, requester i at [i*DIGITS*4 +: DIGITS*4]
//   req_ready  [NUM_REQ]            frame accepted this cycle when valid & ready
//   disp_data  [DIGITS*4]           latched digit buffer
//   disp_owner [$clog2(NUM_REQ)]    last accepted requester
//   disp_busy                       hold window active
//   new_frame                       one-cycle pulse after each buffer update
module x7seg_disp_arb
  import x7seg_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int DIGITS      = 8,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*DIGITS*DIGIT_W-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [DIGITS*DIGIT_W-1:0]         disp_data,
  output logic [$clog2(NUM_REQ)-1:0]        disp_owner,
  output logic                              disp_busy,
  output logic                              new_frame
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam int FW = DIGITS * DIGIT_W;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  arb_state_t        state_q;
  logic [CW-1:0]     cnt_q;
  logic [FW-1:0]     disp_q;
  logic [OW-1:0]     owner_q;
  logic              busy_q;
  logic              nf_q;

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] gnt;
  logic [OW-1:0]      gnt_idx;
  logic [FW-1:0]      gnt_frame;
  logic               xfer;

  // IDLE opens the display to everyone; HOLD restricts it to the owner
  // (plus anyone of higher priority when preemption is built in).
  always_comb begin
    mask = '0;
    if (state_q == IDLE) begin
      mask = '1;
    end else begin
      mask[owner_q] = 1'b1;
`ifdef X7SEG_PREEMPT_EN
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i < int'(owner_q)) mask[i] = 1'b1;
      end
`endif
    end
  end

  x7seg_prio_arb #(
    .N  (NUM_REQ),
    .IW (OW)
  ) u_prio (
    .req_i  (req_valid),
    .mask_i (mask),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign gnt_frame = req_data[gnt_idx*FW +: FW];

  // Any transfer (first grant, refresh or preemption) reloads the window, so a
  // refresh arriving on the expiry cycle naturally keeps the FSM in HOLD.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      disp_q  <= {DIGITS{BLANK_CODE}};
      owner_q <= '0;
      busy_q  <= 1'b0;
      nf_q    <= 1'b0;
    end else if (xfer) begin
      state_q <= HOLD;
      cnt_q   <= HOLD_LOAD;
      disp_q  <= gnt_frame;
      owner_q <= gnt_idx;
      busy_q  <= 1'b1;
      nf_q    <= 1'b1;
    end else begin
      nf_q <= 1'b0;
      if (state_q == HOLD) begin
        if (cnt_q == '0) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign disp_data  = disp_q;
  assign disp_owner = owner_q;
  assign disp_busy  = busy_q;
  assign new_frame  = nf_q;

endmodule

// File: tb/tb_x7seg_disp_arb.sv
// tb/tb_x7seg_disp_arb.sv - scoreboard bench for x7seg_disp_arb against a hold-window model
module tb_x7seg_disp_arb;

  localparam int NR   = 3;
  localparam int DG   = 8;
  localparam int HOLD = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*32-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic [31:0]   disp_data;
  logic [1:0]    disp_owner;
  logic          disp_busy;
  logic          new_frame;

  x7seg_disp_arb #(.NUM_REQ(NR), .DIGITS(DG), .HOLD_CYCLES(HOLD)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .disp_data  (disp_data),
    .disp_owner (disp_owner),
    .disp_busy  (disp_busy),
    .new_frame  (new_frame)
  );

  always #5 sys_clk = ~sys_clk;

  int tests  = 0;
  int errors = 0;

  // Reference model: cycles of ownership left, owner, pending pulse.
  int          hold_left = 0;
  int          m_owner   = 0;
  bit          exp_nf    = 0;
  logic [NR-1:0] last_gnt;
  logic [33:0] sb_q[$];
  logic [31:0] frames [NR];
  logic [NR-1:0] pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] model_ready(input logic [NR-1:0] v);
    logic [NR-1:0] r;
    r = '0;
    if (hold_left == 0) begin
      for (int i = NR - 1; i >= 0; i--) if (v[i]) r = NR'(1) << i;
    end else begin
      if (v[m_owner]) r = NR'(1) << m_owner;
`ifdef X7SEG_PREEMPT_EN
      for (int i = NR - 1; i >= 0; i--) if (v[i] && i < m_owner) r = NR'(1) << i;
`endif
    end
    return r;
  endfunction

  // One clock cycle, entered right after a falling edge.
  task automatic step(input logic [NR-1:0] v);
    logic [NR-1:0] r;
    req_valid = v;
    for (int i = 0; i < NR; i++) req_data[i*32 +: 32] = frames[i];
    #1;
    r = model_ready(v);
    check("ready", 32'(req_ready), 32'(r));
    check("busy", 32'(disp_busy), 32'(hold_left > 0));
    check("new_frame", 32'(new_frame), 32'(exp_nf));
    check("owner", 32'(disp_owner), 32'(m_owner));
    last_gnt = r;
    if (r != '0) begin
      for (int i = 0; i < NR; i++) if (r[i]) m_owner = i;
      sb_q.push_back({m_owner[1:0], frames[m_owner]});
      hold_left = HOLD;
      exp_nf    = 1;
    end else begin
      exp_nf = 0;
      if (hold_left > 0) hold_left--;
    end
    @(negedge sys_clk);
  endtask

  // Monitor: every buffer update must match the next expected frame.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && new_frame) begin
        if (sb_q.size() == 0) begin
          tests++; errors++;
          $display("FAIL sb_unexpected: got %h owner %0d expected none", disp_data, disp_owner);
        end else begin
          e = sb_q.pop_front();
          check("sb_data", disp_data, e[31:0]);
          check("sb_owner", 32'(disp_owner), 32'(e[33:32]));
        end
      end
    end
  end

  initial begin
    int guard;
    frames[0] = 32'h0; frames[1] = 32'h0; frames[2] = 32'h0;
    repeat (3) @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // 1: reset state
    check("rst_disp", disp_data, 32'hFFFF_FFFF);
    check("rst_busy", 32'(disp_busy), 32'd0);
    check("rst_nf", 32'(new_frame), 32'd0);
    step(3'b000);

    // 2+3: req1 and req2 together; req2 waits out req1's window
    frames[1] = 32'h0000_0007;
    frames[2] = 32'h2222_2222;
    step(3'b110);
    check("t2_gnt", 32'(last_gnt), 32'b010);
    guard = 0;
    do begin step(3'b100); guard++; end while (last_gnt == '0 && guard < 20);
    check("t3_wait", guard, HOLD + 1);

    // 4: owner refresh on the expiry cycle
    while (hold_left > 1) step(3'b000);
    frames[2] = 32'hABCD_1234;
    step(3'b100);
    check("t4_refresh", 32'(last_gnt), 32'b100);
    step(3'b000);
    step(3'b000);

    // 5: req0 during req2's hold
    frames[0] = 32'h0C0D_E000;
    guard = 0;
    do begin step(3'b001); guard++; end while (last_gnt == '0 && guard < 20);
`ifdef X7SEG_PREEMPT_EN
    check("t5_preempt", guard, 1);
`else
    check("t5_wait", 32'(last_gnt), 32'b001);
`endif

    // 6: asynchronous reset mid-hold
    step(3'b000);
    #2 sys_rst_n = 1'b0;
    #1;
    check("t6_disp", disp_data, 32'hFFFF_FFFF);
    check("t6_busy", 32'(disp_busy), 32'd0);
    check("t6_nf", 32'(new_frame), 32'd0);
    check("t6_owner", 32'(disp_owner), 32'd0);
    hold_left = 0; m_owner = 0; exp_nf = 0; sb_q.delete();
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Randomized traffic: valid held with stable data until accepted.
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]   = 1'b1;
          frames[i] = $urandom;
        end
      end
      step(pend);
      pend = pend & ~last_gnt;
    end
    step(3'b000);
    step(3'b000);

    tests++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/x7seg_disp_arb.md
# x7seg_disp_arb

Arbiter and owner of the 8-digit seven-segment digit buffer. Several producers need to show values on the shared display: the LeNet inference result, the current image index, and status/error codes. This block grants the display to one producer at a time with a guaranteed minimum hold time. It latches the granted producer's digits into a registered buffer that drives the 7-seg scan driver.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters; index 0 has the highest priority
- DIGITS, 8, digits per frame; each digit is 4 bits
- HOLD_CYCLES, 100_000_000, minimum display ownership in sys_clk cycles (1 s at 100 MHz); must be ≥ 2

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  requester i has a frame pending
- req_data  in  NUM_REQ*DIGITS*4  frames, flattened; requester i at [i*DIGITS*4 +: DIGITS*4]; digit d at [d*4 +: 4] within the frame
- req_ready  out  NUM_REQ  frame accepted this cycle when valid & ready
- disp_data  out  DIGITS*4  latched digit buffer sent to the scan driver
- disp_owner  out  $clog2(NUM_REQ)  index of the last accepted requester
- disp_busy  out  1  hold window active
- new_frame  out  1  one-cycle pulse after each buffer update

## Operation
- FSM states: IDLE and HOLD.
- Reset values:
  - state IDLE
  - disp_data all nibbles 4'hF (blank code)
  - disp_owner 0
  - disp_busy 0
  - new_frame 0
  - hold counter 0
- req_ready is combinational from state, counter and req_valid; it never depends on req_data.
- IDLE:
  - ready is given to the lowest-index requester with valid set; at most one ready bit is high.
  - On a transfer: latch its frame, owner ← i, counter ← HOLD_CYCLES-1, go to HOLD.
- HOLD:
  - Ready is given to the owner only (refresh).
  - A refresh latches the new frame and reloads the counter.
  - Otherwise the counter decrements each cycle.
  - When the counter reaches 0 with no refresh, go to IDLE.
- Expiry and refresh in the same cycle: refresh wins; stay in HOLD with the counter reloaded.
- Leaving HOLD does not blank the display; disp_data keeps the last frame until the next transfer.
- Requesters without ready must hold valid and data stable; the block never drops a pending frame.
- disp_busy = (state == HOLD), registered.
- Counter width is $clog2(HOLD_CYCLES); the counter must never wrap below 0.
- Asserting reset mid-hold immediately restores all reset values; the display shows blanks.

## Timing
- Transfer at rising edge k:
  - disp_data and disp_owner update at edge k.
  - new_frame is high during cycle k→k+1 only.
- A single transfer with no refresh gives exactly HOLD_CYCLES cycles in HOLD.
- After the HOLD→IDLE edge, a waiting requester's ready rises combinationally in that first IDLE cycle, so its transfer happens at the next edge.
- Back-to-back refreshes from the owner are accepted every cycle; new_frame stays high continuously.
- Latency from valid (with ready high) to disp_data change: 1 edge.

## Configuration
- Macro: X7SEG_PREEMPT_EN.
- Defined:
  - In HOLD, a requester with a lower index than the owner also receives ready. The lowest such index wins; it beats an owner refresh in the same cycle.
  - Its transfer replaces the owner and reloads the counter.
- Undefined:
  - Higher-priority requesters wait until HOLD expires.
  - Preemption logic is not synthesized.

## Structure
- Shared package x7seg_pkg holds:
  - DIGIT_W = 4
  - BLANK_CODE = 4'hF
  - typedef digit_buf_t (logic [DIGITS-1:0][DIGIT_W-1:0])
  - enum arb_state_t {IDLE, HOLD}
- Sub-module x7seg_prio_arb:
  - Combinational fixed-priority one-hot picker: input request vector plus enable mask, output one-hot grant and binary index.
  - Instantiated once; the mask selects all requesters in IDLE and owner-only (or owner plus higher priority under the macro) in HOLD.

## Test plan
Bench uses HOLD_CYCLES = 8, NUM_REQ = 3.
1. Reset release, no valids → disp_data = 32'hFFFF_FFFF, busy 0, new_frame 0, all ready 0.
2. Requesters 1 and 2 valid together in IDLE, req1 = 32'h0000_0007 → only ready[1]; disp_data = 32'h0000_0007, owner 1, new_frame 1 cycle, busy for exactly 8 cycles.
3. Requester 2 valid during req1's hold → ready[2] low until expiry; accepted on the first IDLE cycle; owner 2.
4. Owner refresh at the same edge the counter hits 0 → stays in HOLD; counter reloads to 7; new data shown.
5. With X7SEG_PREEMPT_EN, req0 valid mid-hold of req2 → accepted next edge; owner 0; counter reloaded. Without the macro, req0 waits for expiry.
6. Assert sys_rst_n low mid-hold between clock edges → outputs go to reset values asynchronously: blank display, busy 0.
